// File: rtl/uart_hex_disp_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_disp_if
// Description : Bundle between a UART receiver / display driver pair and the
//               hex display block. Carries the received-byte strobe and data
//               towards the display, and the active-low anode, segment and
//               decimal-point lines back out of it.
//                 rx_done_tick : 1-cycle strobe, rx_data is valid
//                 rx_data[7:0] : received byte
//                 an[3:0]      : active-low anodes, an[0] = rightmost digit
//                 seg[6:0]     : active-low segments g,f,e,d,c,b,a
//                 dp           : active-low decimal point
//               master modport: the side producing bytes and consuming the
//               display lines. slave modport: the display block itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_hex_disp_if;
    logic       rx_done_tick;
    logic [7:0] rx_data;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    modport master (
        output rx_done_tick,
        output rx_data,
        input  an,
        input  seg,
        input  dp
    );

    modport slave (
        input  rx_done_tick,
        input  rx_data,
        output an,
        output seg,
        output dp
    );
endinterface
`default_nettype wire

// File: rtl/uart_hex_disp.sv
`default_nettype none
// ============================================================================
// Module      : uart_hex_disp
// Description : Shows the last two received UART bytes as four hex digits on
//               a time-multiplexed, active-low 7-segment display. The newest
//               byte sits on digits 1:0, the byte before it on digits 3:2.
//               Digits whose byte has never been received are blanked.
//               Optional feature (macro UART_HEX_DISP_DP_EN): the decimal
//               point of digit 0 lights for DP_FRAMES refresh frames after
//               every received byte. Without the macro dp is constant 1.
// Parameters  : N         - refresh counter width, one frame = 2^N cycles
//               DP_FRAMES - frames the new-byte decimal point stays lit (1..255)
// Ports       : clk   - system clock, rising edge
//               reset - asynchronous, active-high reset
//               disp  - uart_hex_disp_if.slave (rx_done_tick, rx_data in;
//                       an, seg, dp out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module uart_hex_disp #(
    parameter int N         = 18,
    parameter int DP_FRAMES = 64
) (
    input  logic            clk,
    input  logic            reset,
    uart_hex_disp_if.slave  disp
);

    localparam logic [N-1:0] c_cnt_max = {N{1'b1}};
    localparam logic [6:0]   c_blank   = 7'b1111111;

    // Out-of-range DP_FRAMES would silently truncate in the 8-bit dp counter.
    if (DP_FRAMES < 1 || DP_FRAMES > 255) begin : g_dp_frames_range
        $error("uart_hex_disp: DP_FRAMES must be within 1..255");
    end

    logic [N-1:0] r_cnt;
    logic [7:0]   r_cur;
    logic [7:0]   r_prev;
    logic         r_cur_v;
    logic         r_prev_v;
    logic [3:0]   r_an;
    logic [6:0]   r_seg;
    logic         r_dp;

    logic [1:0]   w_sel;
    logic [3:0]   w_nib;
    logic         w_nib_v;
    logic [3:0]   w_an;
    logic [6:0]   w_seg;
    logic         w_dp;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    // The top two refresh-counter bits pick the digit being driven.
    assign w_sel = r_cnt[N-1 -: 2];

    always_comb begin
        w_nib   = r_cur[3:0];
        w_nib_v = r_cur_v;
        case (w_sel)
            2'd0: begin w_nib = r_cur[3:0];  w_nib_v = r_cur_v;  end
            2'd1: begin w_nib = r_cur[7:4];  w_nib_v = r_cur_v;  end
            2'd2: begin w_nib = r_prev[3:0]; w_nib_v = r_prev_v; end
            default: begin w_nib = r_prev[7:4]; w_nib_v = r_prev_v; end
        endcase
    end

    // Anode stays enabled for a blank digit so the scan timing is unchanged.
    assign w_an  = ~(4'b0001 << w_sel);
    assign w_seg = w_nib_v ? hex_to_seg(w_nib) : c_blank;

`ifdef UART_HEX_DISP_DP_EN
    localparam logic [7:0] c_dp_load = 8'(DP_FRAMES);

    logic [7:0] r_dp_cnt;

    // Counts refresh frames; a new byte reloads it even on a wrap edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_dp_cnt <= 8'd0;
        end else if (disp.rx_done_tick) begin
            r_dp_cnt <= c_dp_load;
        end else if (r_cnt == c_cnt_max && r_dp_cnt != 8'd0) begin
            r_dp_cnt <= r_dp_cnt - 8'd1;
        end
    end

    assign w_dp = !(w_sel == 2'd0 && r_dp_cnt != 8'd0);
`else
    assign w_dp = 1'b1;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= '0;
            r_cur    <= 8'h00;
            r_prev   <= 8'h00;
            r_cur_v  <= 1'b0;
            r_prev_v <= 1'b0;
            r_an     <= 4'b1110;
            r_seg    <= c_blank;
            r_dp     <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (disp.rx_done_tick) begin
                r_prev   <= r_cur;
                r_prev_v <= r_cur_v;
                r_cur    <= disp.rx_data;
                r_cur_v  <= 1'b1;
            end
            r_an  <= w_an;
            r_seg <= w_seg;
            r_dp  <= w_dp;
        end
    end

    assign disp.an  = r_an;
    assign disp.seg = r_seg;
    assign disp.dp  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_uart_hex_disp.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_hex_disp
// Description : Self-checking bench for uart_hex_disp (N=4, DP_FRAMES=2).
//               A time-based model predicts an/seg/dp every cycle; directed
//               byte sequences with literal digit patterns pin the model.
//               Build with UART_HEX_DISP_DP_EN to cover the dp feature.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_hex_disp;

    localparam int N         = 4;
    localparam int DP_FRAMES = 2;
    localparam int FRAME     = 1 << N;
    localparam int DIGIT     = FRAME / 4;
`ifdef UART_HEX_DISP_DP_EN
    localparam int DP_EN     = 1;
`else
    localparam int DP_EN     = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    logic chk_en = 1'b0;
    int   errors = 0;
    int   checks = 0;

    uart_hex_disp_if u_if ();

    uart_hex_disp #(.N(N), .DP_FRAMES(DP_FRAMES)) u_dut (
        .clk   (clk),
        .reset (reset),
        .disp  (u_if)
    );

    always #5 clk = ~clk;

    logic [6:0] c_hex [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // ---------------- behavioural model ----------------
    int         m_t;
    logic [7:0] m_cur, m_prev;
    bit         m_cur_v, m_prev_v;
    int         m_dp;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    function automatic int digit_at(input int t);
        return (t % FRAME) / DIGIT;
    endfunction

    function automatic logic [6:0] model_seg(input int t, input logic [7:0] c, input bit cv,
                                             input logic [7:0] p, input bit pv);
        int         d = digit_at(t);
        logic [7:0] b = (d < 2) ? c : p;
        bit         v = (d < 2) ? cv : pv;
        int         nib = (d % 2 == 0) ? int'(b) % 16 : int'(b) / 16;
        return v ? c_hex[nib] : 7'b1111111;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_t      <= 0;
            m_cur    <= 8'h00;
            m_prev   <= 8'h00;
            m_cur_v  <= 1'b0;
            m_prev_v <= 1'b0;
            m_dp     <= 0;
            exp_an   <= 4'b1110;
            exp_seg  <= 7'b1111111;
            exp_dp   <= 1'b1;
        end else begin
            exp_an  <= 4'(~(1 << digit_at(m_t)));
            exp_seg <= model_seg(m_t, m_cur, m_cur_v, m_prev, m_prev_v);
            exp_dp  <= (DP_EN == 1 && digit_at(m_t) == 0 && m_dp > 0) ? 1'b0 : 1'b1;
            m_t     <= m_t + 1;
            if (u_if.rx_done_tick) begin
                m_prev   <= m_cur;
                m_prev_v <= m_cur_v;
                m_cur    <= u_if.rx_data;
                m_cur_v  <= 1'b1;
                m_dp     <= DP_FRAMES;
            end else if ((m_t % FRAME) == FRAME - 1 && m_dp > 0) begin
                m_dp <= m_dp - 1;
            end
        end
    end

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_an",  {3'b000, u_if.an}, {3'b000, exp_an});
            check("cyc_seg", u_if.seg, exp_seg);
            check("cyc_dp",  {6'd0, u_if.dp}, {6'd0, exp_dp});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input logic [7:0] b);
        @(negedge clk);
        u_if.rx_done_tick = 1'b1;
        u_if.rx_data      = b;
        @(negedge clk);
        u_if.rx_done_tick = 1'b0;
    endtask

    task automatic wait_an(input logic [3:0] target, input string name);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (u_if.an !== target && n < 64);
        if (u_if.an !== target)
            check(name, {3'b000, u_if.an}, {3'b000, target});
    endtask

    task automatic show_digit(input int d, input logic [6:0] exp, input string name);
        logic [3:0] tgt;
        tgt = 4'(~(1 << d));
        wait_an(tgt, name);
        check(name, u_if.seg, exp);
    endtask

    logic [3:0] an_seq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    initial begin
        int lows;
        reset             = 1'b1;
        u_if.rx_done_tick = 1'b0;
        u_if.rx_data      = 8'h00;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_an",  {3'b000, u_if.an}, 7'b0001110);
        check("rst_seg", u_if.seg, 7'b1111111);
        check("rst_dp",  {6'd0, u_if.dp}, 7'd1);

        // Idle scan: anodes step every 4 cycles, display blank.
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            if ((k - 1) % 4 == 0) begin
                check("idle_an", {3'b000, u_if.an}, {3'b000, an_seq[((k - 1) / 4) % 4]});
                check("idle_seg", u_if.seg, 7'b1111111);
                check("idle_dp", {6'd0, u_if.dp}, 7'd1);
            end
        end

        tick(8'h3A);
        show_digit(0, 7'b0001000, "b3A_d0");
        show_digit(1, 7'b0110000, "b3A_d1");
        show_digit(2, 7'b1111111, "b3A_d2");
        show_digit(3, 7'b1111111, "b3A_d3");

        tick(8'hF5);
        show_digit(0, 7'b0010010, "bF5_d0");
        show_digit(1, 7'b0001110, "bF5_d1");
        show_digit(2, 7'b0001000, "bF5_d2");
        show_digit(3, 7'b0110000, "bF5_d3");

        // Back-to-back strobes.
        @(negedge clk);
        u_if.rx_done_tick = 1'b1;
        u_if.rx_data      = 8'h12;
        @(negedge clk);
        u_if.rx_data      = 8'h34;
        @(negedge clk);
        u_if.rx_done_tick = 1'b0;
        show_digit(0, 7'b0011001, "b34_d0");
        show_digit(1, 7'b0110000, "b34_d1");
        show_digit(2, 7'b0100100, "b12_d2");
        show_digit(3, 7'b1111001, "b12_d3");

        // Strobe exactly on the counter wrap edge, then count lit dp cycles.
        wait_an(4'b1011, "align_a");
        wait_an(4'b0111, "align_b");
        @(negedge clk);
        @(negedge clk);
        u_if.rx_done_tick = 1'b1;
        u_if.rx_data      = 8'h55;
        @(negedge clk);
        u_if.rx_done_tick = 1'b0;
        lows = 0;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (u_if.dp === 1'b0) lows++;
        end
        check("dp_low_cycles", 7'(lows), 7'(DP_EN * DP_FRAMES * DIGIT));

        // Asynchronous reset in the middle of a cycle.
        tick(8'hC9);
        repeat (5) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_an",  {3'b000, u_if.an}, 7'b0001110);
        check("mid_rst_seg", u_if.seg, 7'b1111111);
        check("mid_rst_dp",  {6'd0, u_if.dp}, 7'd1);
        @(negedge clk);
        reset = 1'b0;
        tick(8'h07);
        show_digit(0, 7'b1111000, "b07_d0");
        show_digit(1, 7'b1000000, "b07_d1");
        show_digit(2, 7'b1111111, "b07_d2");
        show_digit(3, 7'b1111111, "b07_d3");

        repeat (4) @(negedge clk);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
